// File: rtl/red_pitaya_spi_arb.sv
// Round-robin arbiter that shares one spi_master between NREQ requesters: grants one,
// latches its words, pulses start, tracks busy with a per-phase timeout, returns read data.
module red_pitaya_spi_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned TO_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*16-1:0]   req_h_i,
  input  logic [NREQ*16-1:0]   req_l_i,
  input  logic [NREQ-1:0]      req_rw_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      done_o,
  output logic                 err_o,
  output logic [15:0]          rd_dat_o,
  output logic                 busy_o,
  output logic                 spi_start_o,
  output logic [15:0]          spi_wr_h_o,
  output logic [15:0]          spi_wr_l_o,
  output logic                 spi_rw_o,
  input  logic                 spi_bsy_i,
  input  logic [15:0]          spi_rd_l_i
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Last count value before the phase limit of 2**TO_W-1 cycles is reached.
  localparam logic [TO_W-1:0] CntLast = {{(TO_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {StIdle, StStart, StWaitBsy, StXfer, StDone} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [15:0]       wr_h_q, wr_h_d;
  logic [15:0]       wr_l_q, wr_l_d;
  logic              rw_q, rw_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [15:0]       rd_q, rd_d;

  logic              arb_hit;
  logic [PW-1:0]     arb_idx;
  logic [PW-1:0]     arb_cand;
  int unsigned       arb_tmp;

  // Search upward from ptr+1 so the last winner is considered last.
  always_comb begin
    arb_hit  = 1'b0;
    arb_idx  = '0;
    arb_cand = '0;
    arb_tmp  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      arb_tmp  = (32'(ptr_q) + i + 1) % NREQ;
      arb_cand = PW'(arb_tmp);
      if (!arb_hit && req_i[arb_cand]) begin
        arb_hit = 1'b1;
        arb_idx = arb_cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    wr_h_d  = wr_h_q;
    wr_l_d  = wr_l_q;
    rw_d    = rw_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rd_d    = rd_q;
    unique case (state_q)
      StIdle: begin
        if (arb_hit) begin
          state_d = StStart;
          win_d   = arb_idx;
          gnt_d   = NREQ'(1) << arb_idx;
          wr_h_d  = req_h_i[16*32'(arb_idx) +: 16];
          wr_l_d  = req_l_i[16*32'(arb_idx) +: 16];
          rw_d    = req_rw_i[arb_idx];
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWaitBsy;
      end
      StWaitBsy: begin
        if (spi_bsy_i) begin
          cnt_d   = '0;
          state_d = StXfer;
        end else if (cnt_q >= CntLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StXfer: begin
        if (!spi_bsy_i) begin
          rd_d    = spi_rd_l_i;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q >= CntLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        gnt_d   = '0;
        ptr_d   = win_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      ptr_q   <= PW'(NREQ - 1);
      win_q   <= '0;
      gnt_q   <= '0;
      wr_h_q  <= '0;
      wr_l_q  <= '0;
      rw_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      wr_h_q  <= wr_h_d;
      wr_l_q  <= wr_l_d;
      rw_q    <= rw_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = (state_q == StDone) ? gnt_q : '0;
  assign err_o       = err_q;
  assign rd_dat_o    = rd_q;
  assign busy_o      = (state_q != StIdle);
  assign spi_start_o = (state_q == StStart);
  assign spi_wr_h_o  = wr_h_q;
  assign spi_wr_l_o  = wr_l_q;
  assign spi_rw_o    = rw_q;

endmodule

// File: tb/tb_red_pitaya_spi_arb.sv
// Directed bench for red_pitaya_spi_arb (NREQ=2, TO_W=4) with a behavioural spi_master model
// and a queue of expected transfer results.
module tb_red_pitaya_spi_arb;

  localparam int unsigned NREQ = 2;
  localparam int unsigned TO_W = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  req = '0;
  logic [31:0] req_h = '0;
  logic [31:0] req_l = '0;
  logic [1:0]  req_rw = '0;
  logic [1:0]  gnt, done;
  logic        err, busy, spi_start, spi_rw;
  logic [15:0] rd_dat, spi_wr_h, spi_wr_l;
  logic        spi_bsy;
  logic [15:0] spi_rd = '0;

  // spi_master model controls
  int          bsy_len = 10;
  logic        bsy_never = 1'b0;
  logic        bsy_stuck = 1'b0;
  int          left;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [15:0] h;
    logic [15:0] l;
    logic        rw;
    logic        err;
    logic [15:0] rd;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  red_pitaya_spi_arb #(.NREQ(NREQ), .TO_W(TO_W)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req_i       (req),
    .req_h_i     (req_h),
    .req_l_i     (req_l),
    .req_rw_i    (req_rw),
    .gnt_o       (gnt),
    .done_o      (done),
    .err_o       (err),
    .rd_dat_o    (rd_dat),
    .busy_o      (busy),
    .spi_start_o (spi_start),
    .spi_wr_h_o  (spi_wr_h),
    .spi_wr_l_o  (spi_wr_l),
    .spi_rw_o    (spi_rw),
    .spi_bsy_i   (spi_bsy),
    .spi_rd_l_i  (spi_rd)
  );

  // Busy rises the edge after start and stays high bsy_len cycles.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spi_bsy <= 1'b0;
      left    <= 0;
    end else if (spi_start && !bsy_never) begin
      spi_bsy <= 1'b1;
      left    <= bsy_len;
    end else if (spi_bsy && !bsy_stuck) begin
      left <= left - 1;
      if (left <= 1) spi_bsy <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] g, input logic [15:0] h, input logic [15:0] l,
                      input logic rw, input logic e, input logic [15:0] rd);
    exp_t x;
    x.gnt = g; x.h = h; x.l = l; x.rw = rw; x.err = e; x.rd = rd;
    sb.push_back(x);
  endtask

  task automatic wait_start(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!spi_start && n < 200);
    chk({tag, "_start_seen"}, 32'(spi_start), 1);
    if (sb.size() != 0) begin
      chk({tag, "_gnt"}, 32'(gnt), 32'(sb[0].gnt));
      chk({tag, "_wr_h"}, 32'(spi_wr_h), 32'(sb[0].h));
      chk({tag, "_wr_l"}, 32'(spi_wr_l), 32'(sb[0].l));
      chk({tag, "_rw"}, 32'(spi_rw), 32'(sb[0].rw));
    end
  endtask

  task automatic wait_done(input string tag, output int n);
    exp_t x;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == '0 && n < 200);
    chk({tag, "_sb_pending"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk({tag, "_done"}, 32'(done), 32'(x.gnt));
      chk({tag, "_err"}, 32'(err), 32'(x.err));
      chk({tag, "_rd"}, 32'(rd_dat), 32'(x.rd));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int n;
    int grant;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(spi_start), 0);
    chk("rst_rd", 32'(rd_dat), 0);
    chk("rst_wr_h", 32'(spi_wr_h), 0);
    rstn = 1'b1;

    // Single read from requester 0.
    @(negedge clk);
    bsy_len = 10;
    spi_rd  = 16'h00A5;
    req_h   = {16'h0000, 16'h8012};
    req_l   = '0;
    req_rw  = 2'b01;
    req     = 2'b01;
    push(2'b01, 16'h8012, 16'h0000, 1'b1, 1'b0, 16'h00A5);
    wait_start("t1", n);
    chk("t1_latency", 32'(n), 1);
    wait_done("t1", n);
    chk("t1_xfer_cycles", 32'(n), 32'(2 + bsy_len));
    req = 2'b00;

    // Continuous contention: strict alternation starting at 0 after reset.
    do_reset();
    bsy_len = 3;
    spi_rd  = 16'h3C3C;
    req_h   = {16'h2222, 16'h1111};
    req_l   = {16'hB0B0, 16'hA0A0};
    req_rw  = 2'b10;
    req     = 2'b11;
    for (int i = 0; i < 6; i++) begin
      grant = i % 2;
      push(2'(1 << grant), (grant == 0) ? 16'h1111 : 16'h2222,
           (grant == 0) ? 16'hA0A0 : 16'hB0B0, 1'(grant), 1'b0, 16'h3C3C);
    end
    for (int i = 0; i < 6; i++) begin
      wait_start("t2", n);
      wait_done("t2", n);
    end
    req = 2'b00;

    // Busy never rises: WAIT_BSY timeout, read data retained.
    @(negedge clk);
    bsy_never = 1'b1;
    spi_rd    = 16'hDEAD;
    req_h     = {16'h0000, 16'h4444};
    req_l     = '0;
    req_rw    = 2'b00;
    req       = 2'b01;
    push(2'b01, 16'h4444, 16'h0000, 1'b0, 1'b1, 16'h3C3C);
    wait_start("t3", n);
    req = 2'b00;
    wait_done("t3", n);
    chk("t3_timeout_cycles", 32'(n), 16);
    bsy_never = 1'b0;

    // Busy stuck high: XFER timeout, then a normal transfer.
    @(negedge clk);
    bsy_stuck = 1'b1;
    bsy_len   = 4;
    req_h     = {16'h5555, 16'h0000};
    req       = 2'b10;
    push(2'b10, 16'h5555, 16'h0000, 1'b0, 1'b1, 16'h3C3C);
    wait_start("t4", n);
    req = 2'b00;
    wait_done("t4", n);
    chk("t4_timeout_cycles", 32'(n), 17);
    bsy_stuck = 1'b0;
    repeat (20) @(negedge clk);
    chk("t4_bsy_released", 32'(spi_bsy), 0);
    spi_rd = 16'h7E57;
    req_h  = {16'h0000, 16'h6666};
    req    = 2'b01;
    push(2'b01, 16'h6666, 16'h0000, 1'b0, 1'b0, 16'h7E57);
    wait_start("t4b", n);
    req = 2'b00;
    wait_done("t4b", n);

    // Data and request changed mid-transfer are ignored.
    @(negedge clk);
    bsy_len = 6;
    spi_rd  = 16'h1234;
    req_h   = {16'h0000, 16'hA5A5};
    req     = 2'b01;
    push(2'b01, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 16'h1234);
    wait_start("t6", n);
    @(negedge clk);
    req_h = {16'h0000, 16'hFFFF};
    req   = 2'b00;
    repeat (3) @(negedge clk);
    chk("t6_wr_h_stable", 32'(spi_wr_h), 32'h0000A5A5);
    chk("t6_gnt_held", 32'(gnt), 32'h1);
    wait_done("t6", n);

    // Asynchronous reset during XFER, then pointer back to NREQ-1.
    @(negedge clk);
    bsy_len = 12;
    req_h   = {16'h0000, 16'h9999};
    req     = 2'b01;
    push(2'b01, 16'h9999, 16'h0000, 1'b0, 1'b0, 16'h1234);
    wait_start("t5", n);
    req = 2'b00;
    repeat (4) @(negedge clk);
    chk("t5_in_xfer", 32'(busy), 1);
    #2 rstn = 1'b0;
    #1;
    chk("t5_async_gnt", 32'(gnt), 0);
    chk("t5_async_start", 32'(spi_start), 0);
    chk("t5_async_busy", 32'(busy), 0);
    void'(sb.pop_front());
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_done", 32'(done), 0);
    end
    rstn    = 1'b1;
    bsy_len = 3;
    spi_rd  = 16'hC0DE;
    req_h   = {16'h7777, 16'h0000};
    req     = 2'b10;
    push(2'b10, 16'h7777, 16'h0000, 1'b0, 1'b0, 16'hC0DE);
    wait_start("t5b", n);
    req = 2'b00;
    wait_done("t5b", n);
    @(negedge clk);
    chk("final_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
